rf_multiport_sb: RTL
====================

// Module: rf_multiport_sb
// PURPOSE
//  Parametrised integer register file for the pipelined core: NR read ports, NW write ports,
//  same-cycle write-to-read bypass, and a per-register pending scoreboard. Decode reads
//  operands and allocates rd. Writeback ports (ALU, MEM) retire writes. A busy flag per read
//  port lets hazard logic stall on in-flight destinations. Entry 0 is hard-wired to zero.
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  32  number of architectural registers; power of two, >= 2
//  AW     5   address width = $clog2(NREGS)
//  NR     2   number of read ports, 1..4
//  NW     2   number of write ports, 1..3; a higher index has higher priority
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst        in   1        reset, asynchronous, active-high
//  wr_en      in   NW       per write port: write enable
//  wr_addr    in   NW*AW    packed write addresses; port k uses [k*AW +: AW]
//  wr_data    in   NW*XLEN  packed write data
//  rd_addr    in   NR*AW    packed read addresses
//  rd_data    out  NR*XLEN  packed read data, combinational
//  rd_busy    out  NR       read port j targets a pending register not written this cycle
//  alloc_en   in   1        mark alloc_addr as pending (decode issues an instruction with rd)
//  alloc_addr in   AW       destination being allocated
//  pend_vec   out  NREGS    pending bit per register, registered; bit 0 is always 0
// BEHAVIOUR
//  Reset: while rst is high, all entries are 0 and all pending bits are 0. rd_data therefore
//   reads 0 and rd_busy is 0. Asserting rst mid-operation discards in-flight writes and allocs.
//  Write: at posedge, for each address A != 0, A takes the data of the highest-index port k
//   with wr_en[k] and wr_addr[k] == A. Writes to address 0 are dropped.
//  Read: rd_data[j] is combinational.
//   - Address 0 reads 0.
//   - Otherwise, if any enabled write port targets the same address this cycle, output that
//     port's wr_data, using the same priority as the write. This is zero-latency bypass.
//   - Otherwise, output the stored value.
//  Scoreboard: at posedge, pend[A] is updated as follows:
//   - set if alloc_en and alloc_addr == A != 0;
//   - else cleared if any wr_en[k] with wr_addr[k] == A;
//   - else held.
//   - When alloc and write hit A in the same cycle, alloc wins and pend stays 1 (a new owner).
//   - Writes to a non-pending register are legal and leave pend at 0.
//   - alloc to 0 is ignored.
//  rd_busy[j] = pend[rd_addr[j]] AND no enabled write to rd_addr[j] this cycle. The bypass
//   resolves the hazard in that cycle. Address 0 is never busy.
//  Latency: 0 cycles read; 1 cycle write and pend update; bypass covers the write-to-read gap.
//  No X on rd_data for in-range addresses. Addresses >= NREGS cannot occur (NREGS = 2**AW).
// STRUCTURE
//  rf_pkg: XLEN / NREGS / AW defaults and the ZERO_REG constant; shared with hazard unit.
//  Sub-module rf_wsel (one instance per read port, plus the write path). It is a
//   priority-select of (hit, data) over NW write ports for a given address and is reused by
//   both the write logic and the bypass.
//  Storage: reg [XLEN-1:0] mem [NREGS]. Pending: reg [NREGS-1:0]. Both are on one
//   always_ff block with async rst.
// TESTING
//  1. Reset, then read all 32 regs on both ports -> rd_data = 0, rd_busy = 0, pend_vec = 0.
//  2. Port0 writes x5 = 0xDEADBEEF while port1 reads x5 in the same cycle
//     -> rd_data[1] = 0xDEADBEEF. The next cycle without a write -> still 0xDEADBEEF.
//  3. Port0 and port1 both write x7 (0x11, 0x22) -> stored 0x22, and the bypass read of x7
//     returns 0x22.
//  4. Write x0 = 0xFFFFFFFF and alloc x0 -> x0 reads 0, pend_vec[0] = 0, rd_busy = 0.
//  5. alloc x3, then read x3 -> rd_busy = 1. On a later cycle, write x3 = 0x42 and read
//     x3 -> rd_busy = 0, data 0x42. The following cycle pend_vec[3] = 0.
//  6. alloc x9 and write x9 in the same cycle -> pend_vec[9] = 1 after the edge. Assert rst
//     mid-sequence -> all regs and pend_vec clear asynchronously.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file defaults shared by the register file and the hazard unit.
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rf_wsel.sv
// Priority select over the write ports for one address: reports whether any enabled
// port targets it and, if so, the data of the highest-index such port.
module rf_wsel
    import rf_pkg::*;
#(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::AW,
    parameter int NW   = 2
) (
    input  logic [AW-1:0]      addr_i,
    input  logic [NW-1:0]      wr_en_i,
    input  logic [NW*AW-1:0]   wr_addr_i,
    input  logic [NW*XLEN-1:0] wr_data_i,
    output logic               hit_o,
    output logic [XLEN-1:0]    data_o
);

    // Ascending scan so the last (highest-index) matching port wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < NW; k++) begin
            if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// per-register pending scoreboard; register 0 is hard-wired to zero.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int NREGS = rf_pkg::NREGS,
    parameter int AW    = $clog2(NREGS),
    parameter int NR    = 2,
    parameter int NW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NW-1:0]      wr_en,
    input  logic [NW*AW-1:0]   wr_addr,
    input  logic [NW*XLEN-1:0] wr_data,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR*XLEN-1:0] rd_data,
    output logic [NR-1:0]      rd_busy,
    input  logic               alloc_en,
    input  logic [AW-1:0]      alloc_addr,
    output logic [NREGS-1:0]   pend_vec
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    logic [NREGS-1:0] w_hit;
    logic [XLEN-1:0]  w_data [NREGS];

    // Write path: one priority select per architectural register.
    for (genvar a = 0; a < NREGS; a++) begin : g_wr
        rf_wsel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_wsel_w (
            .addr_i    (AW'(a)),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (w_hit[a]),
            .data_o    (w_data[a])
        );
    end

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            if (w_hit[i]) begin
                mem_d[i] = w_data[i];
            end
            // A same-cycle alloc names a new owner, so it overrides the retiring write.
            if (alloc_en && (alloc_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (w_hit[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        mem_d[0]  = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

    // Read ports: bypass a same-cycle write, otherwise return the stored value.
    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            r_hit;
        logic [XLEN-1:0] r_data;

        assign ra = rd_addr[j*AW +: AW];

        rf_wsel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_wsel_r (
            .addr_i    (ra),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .hit_o     (r_hit),
            .data_o    (r_data)
        );

        assign rd_data[j*XLEN +: XLEN] = (rst || (ra == ZERO_REG)) ? '0
                                       : r_hit ? r_data
                                       : mem_q[ra];
        assign rd_busy[j] = !rst && (ra != ZERO_REG) && pend_q[ra] && !r_hit;
    end

endmodule
